// File: rtl/ram_fetch_unit_pkg.sv
// Definitions shared by the fetch unit and the ram block: RW bus encodings and fetch states.
package ram_fetch_unit_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_RUN      = 2'd1,
    FS_STOPPING = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ram_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: fall-through head, push/pop in the same cycle, flush wins over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset as well so the head word reads as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to the ram and buffers the returned
// words in a prefetch FIFO handed to decode over valid/ready.
module ram_fetch_unit
  import ram_fetch_unit_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  input  logic          stop,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  output logic [AW-1:0] ram_addr,
  output logic [1:0]    ram_rw,
  output logic          ram_enable,
  input  logic [DW-1:0] ram_fetch,
  output logic          busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] IDLE     = FS_IDLE;
  localparam logic [1:0] RUN      = FS_RUN;
  localparam logic [1:0] STOPPING = FS_STOPPING;

  logic [1:0]       state;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    ifpc;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    issue_addr;
  logic             inflight;
  logic             run;
  logic             redir;
  logic             flush;
  logic             pop;
  logic             issue;
  logic [CW-1:0]    count;
  logic [CW-1:0]    used;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW+DW-1:0] head;

  assign run   = (state == RUN);
  assign redir = run && redirect && !stop;
  assign flush = redir || (state == IDLE && start);

  // A stale word landing in a redirect cycle is discarded because the flush beats the push.
  assign instr_valid = !fifo_empty && !redir;
  assign instr       = head[DW-1:0];
  assign instr_pc    = head[AW+DW-1:DW];
  assign pop         = instr_valid && instr_ready;

  // Credit: slots already owned by buffered plus returning words, a same-cycle pop frees one.
  assign used       = redir ? '0 : count + CW'(inflight) - CW'(pop);
  assign issue      = run && !stop && (used < CW'(DEPTH));
  assign issue_addr = redir ? redirect_pc : pc;
  assign busy       = (state != IDLE) || inflight;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    ram_enable = 1'b0;
    ram_rw     = RW_IDLE;
    ram_addr   = addr_q;
    if (issue) begin
      ram_enable = 1'b1;
      ram_rw     = RW_READ;
      ram_addr   = issue_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      ifpc     <= '0;
      addr_q   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= issue_addr + 1'b1;
        ifpc   <= issue_addr;
        addr_q <= issue_addr;
      end else if (state == IDLE && start) begin
        pc <= start_pc;
      end
      case (state)
        IDLE:     if (start) state <= RUN;
        RUN:      if (stop) state <= STOPPING;
        STOPPING: if (!inflight) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .W    (AW + DW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .push (inflight),
    .wdata({ifpc, ram_fetch}),
    .pop  (pop),
    .rdata(head),
    .count(count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(inflight && fifo_full && !pop && !flush));
  a_no_write: assert property (@(posedge clk) disable iff (reset) ram_rw != RW_WRITE);

endmodule

// File: tb/tb_ram_fetch_unit.sv
// Directed bench for ram_fetch_unit with a word-addressed ram model and an in-order stream model.
module tb_ram_fetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          stop;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic [AW-1:0] ram_addr;
  logic [1:0]    ram_rw;
  logic          ram_enable;
  logic [DW-1:0] ram_fetch;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Stream model state (written only by the compare process).
  logic [AW-1:0] exp_pc = '0;
  int            seen_seq = 0;
  int            pop_cnt = 0;
  logic [AW-1:0] issued_q[$];
  logic [AW-1:0] popped_q[$];
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_instr;
  logic [AW-1:0] prev_pc;

  // Stream restart requests (written only by the main process).
  int            load_seq = 0;
  logic [AW-1:0] load_val = '0;

  always #5 clk = ~clk;

  ram_fetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_pc   (start_pc),
    .stop       (stop),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .ram_addr   (ram_addr),
    .ram_rw     (ram_rw),
    .ram_enable (ram_enable),
    .ram_fetch  (ram_fetch),
    .busy       (busy)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a < 8) return 32'hAAAAAAA1 + a;
    return {16'hBBBB, a[15:0]};
  endfunction

  // Ram: one-cycle read latency.
  always @(posedge clk)
    if (ram_enable && ram_rw == 2'b01) ram_fetch <= mem_word(ram_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every accepted word must be the next address of the current stream with that address's word.
  always @(negedge clk) begin
    if (seen_seq != load_seq) begin
      exp_pc   = load_val;
      seen_seq = load_seq;
    end
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      check("rw_encoding", ram_rw, ram_enable ? 2'b01 : 2'b00);
      if (ram_enable) issued_q.push_back(ram_addr);
      if (prev_hold && instr_valid) begin
        check("hold_instr", instr, prev_instr);
        check("hold_pc", instr_pc, prev_pc);
      end
      if (instr_valid && instr_ready) begin
        check("stream_pc", instr_pc, exp_pc);
        check("stream_word", instr, mem_word(exp_pc));
        popped_q.push_back(instr_pc);
        pop_cnt++;
        exp_pc = exp_pc + 1'b1;
      end
      prev_hold  = instr_valid && !instr_ready;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; redirect = 1'b0;
    start_pc = '0; redirect_pc = '0;
    repeat (2) tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic do_start(input logic [AW-1:0] pc);
    load_val = pc;
    load_seq++;
    start    = 1'b1;
    start_pc = pc;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int p0;
    bit found;
    logic [AW-1:0] a;

    reset = 1'b1; start = 1'b0; stop = 1'b0; redirect = 1'b0;
    start_pc = '0; redirect_pc = '0; instr_ready = 1'b1;
    tick;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_rw", ram_rw, 0);
    check("rst_enable", ram_enable, 0);
    check("rst_busy", busy, 0);
    tick;
    reset = 1'b0;
    tick;

    // 1: sequential stream from 0, one word per cycle once the first word appears.
    instr_ready = 1'b1;
    do_start('0);
    wait_valid("t1_first_valid", 10);
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", instr_valid, 1);
      check("t1_instr", instr, 32'hAAAAAAA1 + k);
      check("t1_pc", instr_pc, k);
      if (k < 7) @(negedge clk);
    end

    // 2: decode stalls, exactly DEPTH words are fetched and held, then the stream resumes.
    do_reset;
    instr_ready = 1'b0;
    n0 = issued_q.size();
    do_start('0);
    repeat (5) tick;
    @(negedge clk);
    check("t2_requests", issued_q.size() - n0, DEPTH);
    check("t2_enable_off", ram_enable, 0);
    check("t2_valid", instr_valid, 1);
    check("t2_instr", instr, 32'hAAAAAAA1);
    check("t2_pc", instr_pc, 0);
    tick;
    instr_ready = 1'b1;
    p0 = pop_cnt;
    repeat (12) tick;
    check("t2_resume_count", pop_cnt - p0, 12);

    // 3: redirect to 5 while the read of word 2 is in flight.
    do_reset;
    instr_ready = 1'b1;
    do_start('0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_enable && ram_addr == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_saw_read2", found, 1);
    tick;
    redirect    = 1'b1;
    redirect_pc = 32'd5;
    load_val    = 32'd5;
    load_seq++;
    @(negedge clk);
    check("t3_redir_valid", instr_valid, 0);
    check("t3_redir_enable", ram_enable, 1);
    check("t3_redir_addr", ram_addr, 5);
    tick;
    redirect = 1'b0;
    wait_valid("t3_valid_after", 10);
    check("t3_instr", instr, 32'hAAAAAAA6);
    check("t3_pc", instr_pc, 5);

    // 4: stop with a read in flight; START while stopping is ignored.
    repeat (3) tick;
    a  = issued_q[issued_q.size() - 1];
    n0 = issued_q.size();
    stop = 1'b1;
    @(negedge clk);
    check("t4_stop_enable", ram_enable, 0);
    check("t4_busy_stop", busy, 1);
    tick;
    stop     = 1'b0;
    start    = 1'b1;
    start_pc = 32'd100;
    @(negedge clk);
    check("t4_busy_stopping", busy, 1);
    tick;
    start = 1'b0;
    @(negedge clk);
    check("t4_busy_idle", busy, 0);
    check("t4_last_word_pc", popped_q[popped_q.size() - 1], a);
    repeat (5) tick;
    @(negedge clk);
    check("t4_no_requests", issued_q.size() - n0, 0);
    check("t4_enable_idle", ram_enable, 0);
    check("t4_fifo_drained", instr_valid, 0);

    // 5: PC wraps from all-ones to zero.
    do_reset;
    instr_ready = 1'b1;
    n0 = issued_q.size();
    p0 = popped_q.size();
    do_start(32'hFFFFFFFF);
    repeat (4) tick;
    check("t5_two_requests", issued_q.size() - n0 >= 2, 1);
    check("t5_addr0", issued_q[n0], 32'hFFFFFFFF);
    check("t5_addr1", issued_q[n0 + 1], 0);
    check("t5_two_words", popped_q.size() - p0 >= 2, 1);
    check("t5_pop0", popped_q[p0], 32'hFFFFFFFF);
    check("t5_pop1", popped_q[p0 + 1], 0);

    // 6: asynchronous reset mid-run clears outputs immediately.
    repeat (2) tick;
    #3;
    reset = 1'b1;
    #1;
    check("t6_valid", instr_valid, 0);
    check("t6_instr", instr, 0);
    check("t6_instr_pc", instr_pc, 0);
    check("t6_addr", ram_addr, 0);
    check("t6_rw", ram_rw, 0);
    check("t6_enable", ram_enable, 0);
    check("t6_busy", busy, 0);
    repeat (2) tick;
    reset = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    check("t6_post_valid", instr_valid, 0);
    check("t6_post_busy", busy, 0);
    check("t6_post_enable", ram_enable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
